bram_rmw_controller: RTL
========================

Name: bram_rmw_controller

Overview:
- Request-side initiator for the single-read/single-write-port block RAM (ram_style block; 1-cycle registered read; same-cycle write-to-read forwarding; readData = 0 when read not enabled).
- Accepts core load/store requests on a valid/ready handshake and drives the RAM's read and write ports.
- Converts byte-enabled partial stores into read-modify-write sequences, because the RAM has no byte enables.
- Returns load data with fixed 1-cycle latency; sits between pipeline memory stage and RAM.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8
ADDR_WIDTH, 8, word address width; must match attached RAM
(derived) BYTES = DATA_WIDTH/8, byte-lane count

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept request this cycle
req_write  input  1  1 = store, 0 = load
req_address  input  ADDR_WIDTH  word address
req_byte_en  input  BYTES  store byte-lane enables; ignored for loads
req_data  input  DATA_WIDTH  store data
resp_valid  output  1  load data valid
resp_data  output  DATA_WIDTH  load data
bram_read_enable  output  1  to RAM readEnable
bram_read_address  output  ADDR_WIDTH  to RAM readAddress
bram_read_data  input  DATA_WIDTH  from RAM readData
bram_write_enable  output  1  to RAM writeEnable
bram_write_address  output  ADDR_WIDTH  to RAM writeAddress
bram_write_data  output  DATA_WIDTH  to RAM writeData
read_count / write_count / rmw_count  output  32 each  performance counters (see Optional Feature)

Behaviour:
- Reset (reset = 0, async):
  - state = IDLE; req_ready = 0 while asserted.
  - resp_valid = 0, resp_data = 0; all bram_* enables 0; counters 0.
  - Any pending RMW is dropped; no write is issued after reset.
- Handshake: a request is accepted on a clock edge where req_valid & req_ready. RAM-port outputs are combinational from the request in the accept cycle.
- States: IDLE, LOAD_RESP, RMW_READ, RMW_WRITE.
- req_ready = 1 in IDLE and LOAD_RESP; 0 in RMW_READ and RMW_WRITE.
- Load accept:
  - bram_read_enable = 1, bram_read_address = req_address; next state LOAD_RESP.
  - Back-to-back loads sustain one per cycle.
- LOAD_RESP:
  - resp_valid = 1, resp_data = bram_read_data (pass-through; the RAM output is already registered).
  - If no new load is accepted, return to IDLE.
  - Outside LOAD_RESP: resp_valid = 0, resp_data = 0.
- Full store (req_byte_en all ones):
  - bram_write_enable = 1 in the accept cycle; address/data from the request.
  - Next state IDLE. No response.
- Partial store (req_byte_en neither all ones nor zero), 3 cycles total:
  - Accept cycle: register address, data and byte_en; issue RAM read of req_address; next state RMW_READ.
  - RMW_READ: wait for RAM data; no RAM activity.
  - RMW_WRITE: lane i = byte_en_q[i] ? data_q lane i : bram_read_data lane i; issue write to address_q; next state IDLE.
- Zero-enable store: accepted, no RAM activity, no response, 1 cycle.
- Hazards:
  - Store followed by load to the same address in the next cycle returns the new data.
  - Load issued in the same cycle as an RMW write cannot occur (req_ready = 0).
- Read and write enables never both assert for different requests in one cycle except as stated above.
- Address wrap: none. Addresses are word indices 0 .. 2^ADDR_WIDTH-1.
- Reset mid-RMW (in RMW_READ or RMW_WRITE): write suppressed; memory keeps its old word.

Optional Feature:
- Macro: BRAM_CTRL_PERF_EN.
- Defined:
  - read_count increments per accepted load; write_count increments per accepted store with nonzero byte_en; rmw_count increments per partial store at entry to RMW_READ.
  - All counters wrap at 2^32 and clear on reset.
- Undefined: counter ports remain, tied to 0, no counter flops.

Test Plan:
- Store 0xDEADBEEF to addr 0x10 with byte_en 4'b1111, then load 0x10 next cycle -> resp_valid one cycle after load accept, resp_data = 0xDEADBEEF.
- With word 0x11223344 at addr 0x20, store 0xAABBCCDD with byte_en 4'b0101 -> req_ready low 2 cycles; reload gives 0x11BB33DD; with PERF_EN, rmw_count = 1.
- Loads to 0x00, 0x01, 0x02 on consecutive cycles (words 0xA, 0xB, 0xC) -> resp_valid high 3 consecutive cycles with 0xA, 0xB, 0xC.
- Store with byte_en 4'b0000 to 0x30 holding 0x55 -> no bram_write_enable; reload gives 0x55; write_count unchanged.
- Assert reset during RMW_READ of a partial store to 0x40 holding 0x12345678 -> all outputs 0 immediately; after release req_ready = 1; reload 0x40 gives 0x12345678.
- Load followed immediately by a partial store, then a load to the same address -> req_ready deasserts for exactly 2 cycles; the final load returns the merged word.

Source files
------------

// File: rtl/bram_rmw_controller.sv
// Load/store front end for a byte-enable-less block RAM: partial stores become read-modify-write.
// Optional performance counters are built when BRAM_CTRL_PERF_EN is defined; otherwise they read 0.
module bram_rmw_controller #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_address,
  input  logic [DATA_WIDTH/8-1:0] req_byte_en,
  input  logic [DATA_WIDTH-1:0]   req_data,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_data,
  output logic                    bram_read_enable,
  output logic [ADDR_WIDTH-1:0]   bram_read_address,
  input  logic [DATA_WIDTH-1:0]   bram_read_data,
  output logic                    bram_write_enable,
  output logic [ADDR_WIDTH-1:0]   bram_write_address,
  output logic [DATA_WIDTH-1:0]   bram_write_data,
  output logic [31:0]             read_count,
  output logic [31:0]             write_count,
  output logic [31:0]             rmw_count
);

  localparam int BYTES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_RESP = 2'd1,
    RMW_READ  = 2'd2,
    RMW_WRITE = 2'd3
  } state_t;

  state_t state, state_next;

  logic                  accept;
  logic                  full_store;
  logic                  zero_store;
  logic                  partial_store;
  logic [ADDR_WIDTH-1:0] address_p1;
  logic [DATA_WIDTH-1:0] data_p1;
  logic [BYTES-1:0]      byte_en_p1;
  logic [DATA_WIDTH-1:0] rdata_p2;

  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [BYTES-1:0]      lanes
  );
    logic [DATA_WIDTH-1:0] result;
    result = old_word;
    for (int i = 0; i < BYTES; i++) begin
      if (lanes[i]) result[8*i +: 8] = new_word[8*i +: 8];
    end
    return result;
  endfunction

  assign full_store    = &req_byte_en;
  assign zero_store    = ~|req_byte_en;
  assign partial_store = !full_store && !zero_store;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // p1: partial-store request captured at accept
  always_ff @(posedge clock) begin
    if (accept && req_write && partial_store) begin
      address_p1 <= req_address;
      data_p1    <= req_data;
      byte_en_p1 <= req_byte_en;
    end
  end

  // p2: old word held, because the RAM zeroes readData once readEnable drops
  always_ff @(posedge clock) begin
    if (state == RMW_READ) rdata_p2 <= bram_read_data;
  end

  always_comb begin
    state_next         = state;
    req_ready          = 1'b0;
    accept             = 1'b0;
    resp_valid         = 1'b0;
    resp_data          = '0;
    bram_read_enable   = 1'b0;
    bram_read_address  = req_address;
    bram_write_enable  = 1'b0;
    bram_write_address = req_address;
    bram_write_data    = req_data;

    case (state)
      IDLE: begin
        req_ready = reset;
      end
      LOAD_RESP: begin
        req_ready  = reset;
        resp_valid = 1'b1;
        resp_data  = bram_read_data;
        state_next = IDLE;
      end
      RMW_READ: begin
        state_next = RMW_WRITE;
      end
      RMW_WRITE: begin
        bram_write_enable  = 1'b1;
        bram_write_address = address_p1;
        bram_write_data    = merge_lanes(data_p1, rdata_p2, byte_en_p1);
        state_next         = IDLE;
      end
      default: state_next = IDLE;
    endcase

    accept = req_valid && req_ready;
    if (accept) begin
      if (!req_write) begin
        bram_read_enable = 1'b1;
        state_next       = LOAD_RESP;
      end else if (full_store) begin
        bram_write_enable = 1'b1;
        state_next        = IDLE;
      end else if (partial_store) begin
        bram_read_enable = 1'b1;
        state_next       = RMW_READ;
      end else begin
        state_next = IDLE;
      end
    end
  end

`ifdef BRAM_CTRL_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      read_count  <= '0;
      write_count <= '0;
      rmw_count   <= '0;
    end else if (accept) begin
      if (!req_write)                 read_count  <= read_count + 32'd1;
      if (req_write && !zero_store)   write_count <= write_count + 32'd1;
      if (req_write && partial_store) rmw_count   <= rmw_count + 32'd1;
    end
  end
`else
  assign read_count  = '0;
  assign write_count = '0;
  assign rmw_count   = '0;
`endif

endmodule
